// File: rtl/leiwand_rv32_bus_pkg.sv
// Shared bus definitions: arbiter state encoding, write-size codes and a
// width helper used by the arbiter, RAM and core.
package leiwand_rv32_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        ABORT  = 2'd3
    } bus_state_e;

    localparam logic [2:0] WR_SIZE_BYTE = 3'd1;
    localparam logic [2:0] WR_SIZE_HALF = 3'd2;
    localparam logic [2:0] WR_SIZE_WORD = 3'd4;

    // Number of bits needed to hold the value itself (not value-1).
    function automatic int HIGH_BIT_TO_FIT(input int value);
        int bits;
        bits = 1;
        while ((1 << bits) <= value) begin
            bits++;
        end
        return bits;
    endfunction

endpackage

// File: rtl/leiwand_rv32_bus_watchdog.sv
// Slave-ack watchdog: counts unacknowledged granted cycles and flags the
// cycle in which the count reaches the timeout limit.
module leiwand_rv32_bus_watchdog
    import leiwand_rv32_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CNT_W = HIGH_BIT_TO_FIT(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // The counted cycle that would bring the count to the limit is the expiry cycle.
    assign o_expire = i_enable && (count_q >= LAST);

    // Next count: clear wins, otherwise saturating increment while enabled.
    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/leiwand_rv32_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single shared slave (RAM).
// M0 is instruction fetch, M1 is load/store. A watchdog aborts a grant whose
// slave never acknowledges.
module leiwand_rv32_bus_arbiter
    import leiwand_rv32_bus_pkg::*;
#(
    parameter int MEM_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_m0_cyc,
    input  logic                 i_m0_stb,
    input  logic                 i_m0_we,
    input  logic [MEM_WIDTH-1:0] i_m0_addr,
    input  logic [MEM_WIDTH-1:0] i_m0_dat,
    input  logic [2:0]           i_m0_wr_size,
    output logic [MEM_WIDTH-1:0] o_m0_dat,
    output logic                 o_m0_ack,
    output logic                 o_m0_stall,
    output logic                 o_m0_err,
    input  logic                 i_m1_cyc,
    input  logic                 i_m1_stb,
    input  logic                 i_m1_we,
    input  logic [MEM_WIDTH-1:0] i_m1_addr,
    input  logic [MEM_WIDTH-1:0] i_m1_dat,
    input  logic [2:0]           i_m1_wr_size,
    output logic [MEM_WIDTH-1:0] o_m1_dat,
    output logic                 o_m1_ack,
    output logic                 o_m1_stall,
    output logic                 o_m1_err,
    output logic                 o_s_cyc,
    output logic                 o_s_stb,
    output logic                 o_s_we,
    output logic [MEM_WIDTH-1:0] o_s_addr,
    output logic [MEM_WIDTH-1:0] o_s_dat,
    output logic [2:0]           o_s_wr_size,
    input  logic [MEM_WIDTH-1:0] i_s_dat,
    input  logic                 i_s_ack,
    input  logic                 i_s_stall
);

    bus_state_e state_q;
    bus_state_e state_d;
    logic       lastOwner_q;
    logic       lastOwner_d;

    logic granted;
    logic ownerCyc;
    logic abortOwnerCyc;
    logic wdClear;
    logic wdEnable;
    logic wdExpire;

    assign granted       = (state_q == GRANT0) || (state_q == GRANT1);
    assign ownerCyc      = ((state_q == GRANT0) && i_m0_cyc) || ((state_q == GRANT1) && i_m1_cyc);
    assign abortOwnerCyc = lastOwner_q ? i_m1_cyc : i_m0_cyc;

    // The watchdog only runs while a grant is open and the slave stays silent.
    assign wdClear  = !granted || i_s_ack;
    assign wdEnable = ownerCyc && !i_s_ack;

    leiwand_rv32_bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (wdClear),
        .i_enable (wdEnable),
        .o_expire (wdExpire)
    );

    // Next-state arbitration and output muxing; non-owners always see a stall.
    always_comb begin
        state_d     = state_q;
        lastOwner_d = lastOwner_q;
        o_s_cyc     = 1'b0;
        o_s_stb     = 1'b0;
        o_s_we      = 1'b0;
        o_s_addr    = '0;
        o_s_dat     = '0;
        o_s_wr_size = '0;
        o_m0_dat    = '0;
        o_m0_ack    = 1'b0;
        o_m0_stall  = 1'b1;
        o_m0_err    = 1'b0;
        o_m1_dat    = '0;
        o_m1_ack    = 1'b0;
        o_m1_stall  = 1'b1;
        o_m1_err    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_m0_cyc && i_m1_cyc) begin
                    state_d     = lastOwner_q ? GRANT0 : GRANT1;
                    lastOwner_d = !lastOwner_q;
                end else if (i_m0_cyc) begin
                    state_d     = GRANT0;
                    lastOwner_d = 1'b0;
                end else if (i_m1_cyc) begin
                    state_d     = GRANT1;
                    lastOwner_d = 1'b1;
                end
            end
            GRANT0: begin
                o_s_cyc     = i_m0_cyc && !wdExpire;
                o_s_stb     = i_m0_stb && !wdExpire;
                o_s_we      = i_m0_we;
                o_s_addr    = i_m0_addr;
                o_s_dat     = i_m0_dat;
                o_s_wr_size = i_m0_wr_size;
                o_m0_dat    = i_s_dat;
                o_m0_ack    = i_s_ack;
                o_m0_stall  = i_s_stall;
                o_m0_err    = wdExpire;
                if (!i_m0_cyc) begin
                    state_d = IDLE;
                end else if (wdExpire) begin
                    state_d = ABORT;
                end
            end
            GRANT1: begin
                o_s_cyc     = i_m1_cyc && !wdExpire;
                o_s_stb     = i_m1_stb && !wdExpire;
                o_s_we      = i_m1_we;
                o_s_addr    = i_m1_addr;
                o_s_dat     = i_m1_dat;
                o_s_wr_size = i_m1_wr_size;
                o_m1_dat    = i_s_dat;
                o_m1_ack    = i_s_ack;
                o_m1_stall  = i_s_stall;
                o_m1_err    = wdExpire;
                if (!i_m1_cyc) begin
                    state_d = IDLE;
                end else if (wdExpire) begin
                    state_d = ABORT;
                end
            end
            ABORT: begin
                if (!abortOwnerCyc) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and last-owner registers; reset makes M0 win the first tie.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            lastOwner_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            lastOwner_q <= lastOwner_d;
        end
    end

endmodule

// File: tb/tb_leiwand_rv32_bus_arbiter.sv
// Self-checking bench for leiwand_rv32_bus_arbiter with a small RAM model
// behind the slave port.
module tb_leiwand_rv32_bus_arbiter;
    import leiwand_rv32_bus_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rstN;
    logic         m0Cyc, m0Stb, m0We, m0Ack, m0Stall, m0Err;
    logic [W-1:0] m0Addr, m0WDat, m0RDat;
    logic [2:0]   m0WrSize;
    logic         m1Cyc, m1Stb, m1We, m1Ack, m1Stall, m1Err;
    logic [W-1:0] m1Addr, m1WDat, m1RDat;
    logic [2:0]   m1WrSize;
    logic         sCyc, sStb, sWe, sAck, sStall;
    logic [W-1:0] sAddr, sWDat, sRDat;
    logic [2:0]   sWrSize;
    logic         ackEnable;
    logic [W-1:0] mem [0:63];

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic         m0Cyc;
        logic         m1Cyc;
        logic         expM0Ack;
        logic         expM0Stall;
        logic         expM1Ack;
        logic         expM1Stall;
        logic         expSCyc;
        logic [W-1:0] expSAddr;
        logic [W-1:0] expM0Dat;
        logic [W-1:0] expM1Dat;
    } vec_t;

    vec_t vecs [10];

    always #5 clk = ~clk;

    leiwand_rv32_bus_arbiter #(
        .MEM_WIDTH      (W),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_m0_cyc     (m0Cyc),
        .i_m0_stb     (m0Stb),
        .i_m0_we      (m0We),
        .i_m0_addr    (m0Addr),
        .i_m0_dat     (m0WDat),
        .i_m0_wr_size (m0WrSize),
        .o_m0_dat     (m0RDat),
        .o_m0_ack     (m0Ack),
        .o_m0_stall   (m0Stall),
        .o_m0_err     (m0Err),
        .i_m1_cyc     (m1Cyc),
        .i_m1_stb     (m1Stb),
        .i_m1_we      (m1We),
        .i_m1_addr    (m1Addr),
        .i_m1_dat     (m1WDat),
        .i_m1_wr_size (m1WrSize),
        .o_m1_dat     (m1RDat),
        .o_m1_ack     (m1Ack),
        .o_m1_stall   (m1Stall),
        .o_m1_err     (m1Err),
        .o_s_cyc      (sCyc),
        .o_s_stb      (sStb),
        .o_s_we       (sWe),
        .o_s_addr     (sAddr),
        .o_s_dat      (sWDat),
        .o_s_wr_size  (sWrSize),
        .i_s_dat      (sRDat),
        .i_s_ack      (sAck),
        .i_s_stall    (sStall)
    );

    // RAM model: zero-wait combinational read/ack, ack can be suppressed.
    assign sAck  = ackEnable && sCyc && sStb;
    assign sRDat = (sCyc && sStb) ? mem[sAddr[7:2]] : '0;

    // RAM write with byte/half/word lanes selected by the low address bits.
    always @(posedge clk) begin
        if (sCyc && sStb && sWe && sAck) begin
            case (sWrSize)
                WR_SIZE_BYTE: mem[sAddr[7:2]][{sAddr[1:0], 3'b000} +: 8]  <= sWDat[7:0];
                WR_SIZE_HALF: mem[sAddr[7:2]][{sAddr[1], 4'b0000} +: 16] <= sWDat[15:0];
                default:      mem[sAddr[7:2]] <= sWDat;
            endcase
        end
    end

    task automatic checkBit(input string name, input logic actual, input logic expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic checkWord(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Master 0 always reads a word; master 1 can read or write any size.
    task automatic applyStimulus(input logic c0, input logic [W-1:0] a0,
                                 input logic c1, input logic we1, input logic [W-1:0] a1,
                                 input logic [W-1:0] d1, input logic [2:0] sz1);
        m0Cyc    = c0;
        m0Stb    = c0;
        m0We     = 1'b0;
        m0Addr   = a0;
        m0WDat   = '0;
        m0WrSize = WR_SIZE_WORD;
        m1Cyc    = c1;
        m1Stb    = c1;
        m1We     = we1;
        m1Addr   = a1;
        m1WDat   = d1;
        m1WrSize = sz1;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation did not end, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  32'h0,         32'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 32'h1234_5678, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0,         32'h0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  32'h0,         32'h0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 32'h0,         32'h1122_3344};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0,         32'h0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  32'h0,         32'h0};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 32'h1234_5678, 32'h0};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0,         32'h0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  32'h0,         32'h0};

        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'h0;
        end
        mem[4]    = 32'h1234_5678;
        mem[8]    = 32'h1122_3344;
        sStall    = 1'b0;
        ackEnable = 1'b1;
        rstN      = 1'b0;
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, WR_SIZE_WORD);

        // Reset state, with M0 already requesting.
        #2;
        checkBit("reset_m0_stall", m0Stall, 1'b1);
        checkBit("reset_m1_stall", m1Stall, 1'b1);
        checkBit("reset_m0_ack", m0Ack, 1'b0);
        checkBit("reset_m0_err", m0Err, 1'b0);
        checkBit("reset_s_cyc", sCyc, 1'b0);
        checkWord("reset_s_addr", sAddr, 32'h0);
        checkWord("reset_m0_dat", m0RDat, 32'h0);
        stepCycle();
        stepCycle();
        checkBit("reset_hold_s_cyc", sCyc, 1'b0);
        rstN = 1'b1;

        // Round-robin table: tie to M0, dead cycle, M1, tie back to M0.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].m0Cyc, 32'h10, vecs[i].m1Cyc, 1'b0, 32'h20, 32'h0, WR_SIZE_WORD);
            #3;
            checkBit($sformatf("vec%0d_m0_ack", i), m0Ack, vecs[i].expM0Ack);
            checkBit($sformatf("vec%0d_m0_stall", i), m0Stall, vecs[i].expM0Stall);
            checkBit($sformatf("vec%0d_m1_ack", i), m1Ack, vecs[i].expM1Ack);
            checkBit($sformatf("vec%0d_m1_stall", i), m1Stall, vecs[i].expM1Stall);
            checkBit($sformatf("vec%0d_s_cyc", i), sCyc, vecs[i].expSCyc);
            checkWord($sformatf("vec%0d_s_addr", i), sAddr, vecs[i].expSAddr);
            checkWord($sformatf("vec%0d_m0_dat", i), m0RDat, vecs[i].expM0Dat);
            checkWord($sformatf("vec%0d_m1_dat", i), m1RDat, vecs[i].expM1Dat);
            stepCycle();
        end

        // M1 byte write to 0x21 while M0 is pending (M0 was last owner).
        applyStimulus(1'b1, 32'h20, 1'b1, 1'b1, 32'h21, 32'h0000_00AB, WR_SIZE_BYTE);
        #3;
        checkBit("bw_idle_s_cyc", sCyc, 1'b0);
        stepCycle();
        #3;
        checkBit("bw_s_cyc", sCyc, 1'b1);
        checkBit("bw_s_we", sWe, 1'b1);
        checkWord("bw_s_addr", sAddr, 32'h21);
        checkWord("bw_s_wr_size", {29'b0, sWrSize}, 32'd1);
        checkWord("bw_s_dat", sWDat, 32'h0000_00AB);
        checkBit("bw_m1_ack", m1Ack, 1'b1);
        checkBit("bw_m0_stall", m0Stall, 1'b1);
        stepCycle();
        applyStimulus(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, WR_SIZE_WORD);
        #3;
        checkBit("bw_release_m0_stall", m0Stall, 1'b1);
        stepCycle();
        #3;
        checkBit("bw_dead_m0_stall", m0Stall, 1'b1);
        checkBit("bw_dead_s_cyc", sCyc, 1'b0);
        stepCycle();
        #3;
        checkBit("rd20_m0_ack", m0Ack, 1'b1);
        checkWord("rd20_m0_dat", m0RDat, 32'h1122_AB44);
        checkWord("rd20_byte1", {24'b0, m0RDat[15:8]}, 32'h0000_00AB);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, WR_SIZE_WORD);
        #3;
        stepCycle();

        // Watchdog: no slave ack, M0 granted, M1 waiting behind it.
        ackEnable = 1'b0;
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, WR_SIZE_WORD);
        #3;
        stepCycle();
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 32'h24, 32'h0, WR_SIZE_WORD);
            #3;
            checkBit($sformatf("wd%0d_m0_err", k), m0Err, (k == 4));
            checkBit($sformatf("wd%0d_s_cyc", k), sCyc, (k < 4));
            checkBit($sformatf("wd%0d_m0_ack", k), m0Ack, 1'b0);
            checkBit($sformatf("wd%0d_m0_stall", k), m0Stall, (k >= 5));
            checkBit($sformatf("wd%0d_m1_stall", k), m1Stall, 1'b1);
            checkBit($sformatf("wd%0d_m1_err", k), m1Err, 1'b0);
            stepCycle();
        end
        applyStimulus(1'b0, 32'h10, 1'b1, 1'b0, 32'h24, 32'h0, WR_SIZE_WORD);
        #3;
        checkBit("abort_exit_m1_stall", m1Stall, 1'b1);
        checkBit("abort_exit_s_cyc", sCyc, 1'b0);
        stepCycle();
        #3;
        checkBit("abort_dead_m1_stall", m1Stall, 1'b1);
        stepCycle();
        ackEnable = 1'b1;
        #3;
        checkBit("after_abort_m1_ack", m1Ack, 1'b1);
        checkWord("after_abort_s_addr", sAddr, 32'h24);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, WR_SIZE_WORD);
        #3;
        stepCycle();

        // Asynchronous reset in the middle of an M1 write.
        ackEnable = 1'b0;
        applyStimulus(1'b0, 32'h10, 1'b1, 1'b1, 32'h30, 32'h55, WR_SIZE_WORD);
        #3;
        stepCycle();
        #1;
        checkBit("pre_rst_s_cyc", sCyc, 1'b1);
        #1;
        rstN = 1'b0;
        #1;
        checkBit("arst_s_cyc", sCyc, 1'b0);
        checkBit("arst_s_we", sWe, 1'b0);
        checkWord("arst_s_addr", sAddr, 32'h0);
        checkWord("arst_s_dat", sWDat, 32'h0);
        checkBit("arst_m1_stall", m1Stall, 1'b1);
        checkBit("arst_m1_ack", m1Ack, 1'b0);
        checkBit("arst_m1_err", m1Err, 1'b0);
        checkBit("arst_m0_stall", m0Stall, 1'b1);
        ackEnable = 1'b1;
        applyStimulus(1'b1, 32'h10, 1'b1, 1'b1, 32'h30, 32'h55, WR_SIZE_WORD);
        stepCycle();
        stepCycle();
        rstN = 1'b1;
        #3;
        checkBit("post_rst_idle_s_cyc", sCyc, 1'b0);
        stepCycle();
        #3;
        checkWord("post_rst_tie_s_addr", sAddr, 32'h10);
        checkBit("post_rst_tie_m0_stall", m0Stall, 1'b0);
        checkBit("post_rst_tie_m0_ack", m0Ack, 1'b1);
        checkBit("post_rst_tie_m1_stall", m1Stall, 1'b1);
        checkWord("post_rst_mem12", mem[12], 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/leiwand_rv32_bus_arbiter.md
LEIWAND_RV32_BUS_ARBITER -- requirements
Module: leiwand_rv32_bus_arbiter

Interface
REQ-001 Parameter MEM_WIDTH, default 32: address/data width of all ports.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: slave-ack watchdog limit, in cycles; minimum 2.
REQ-003 i_clk  input  1  single clock; all state changes on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_mN_cyc, i_mN_stb, i_mN_we (N=0,1)  input  1 each  master N bus cycle, strobe, write enable; M0 = instruction fetch, M1 = load/store.
REQ-006 i_mN_addr, i_mN_dat  input  MEM_WIDTH each  master N address, write data.
REQ-007 i_mN_wr_size  input  3  master N write size in bytes: 1, 2 or 4.
REQ-008 o_mN_dat  output  MEM_WIDTH  read data to master N.
REQ-009 o_mN_ack, o_mN_stall, o_mN_err  output  1 each  acknowledge, stall and watchdog error to master N.
REQ-010 o_s_cyc, o_s_stb, o_s_we  output  1 each  to shared slave (RAM).
REQ-011 o_s_addr, o_s_dat  output  MEM_WIDTH each; o_s_wr_size  output  3.
REQ-012 i_s_dat  input  MEM_WIDTH; i_s_ack, i_s_stall  input  1 each  from slave.

Function
REQ-013 FSM states: IDLE, GRANT0, GRANT1, ABORT; state held in a registered variable.
REQ-014 IDLE: if any i_mN_cyc high, grant next cycle; both high -> master that is not last_owner wins; one high -> that master.
REQ-015 last_owner register updated to N on every entry into GRANTN.
REQ-016 Arbitration latency exactly one cycle: request seen in IDLE at edge k, slave signals driven from owner from cycle k+1.
REQ-017 GRANTN: o_s_cyc/stb/we/addr/dat/wr_size combinationally equal owner's inputs; o_mN_stall = i_s_stall; o_mN_ack = i_s_ack; o_mN_dat = i_s_dat.
REQ-018 Non-owner in any state: o_stall=1, o_ack=0, o_err=0, o_dat=0; its request is held pending, never dropped.
REQ-019 Outside GRANTN all o_s_* outputs are 0.
REQ-020 GRANTN -> IDLE on the edge where owner's i_mN_cyc is low; grant is never revoked while owner cyc high (except watchdog).
REQ-021 Owner cyc dropping with slave ack in same cycle: ack still forwarded that cycle, then IDLE.
REQ-022 Watchdog counter: cleared on grant entry and on every cycle with i_s_ack=1; increments each GRANTN cycle with owner cyc high and i_s_ack=0; saturates, never wraps.
REQ-023 Counter reaching TIMEOUT_CYCLES: o_mN_err=1 for exactly one cycle to owner, o_s_cyc forced 0 from that cycle, state -> ABORT.
REQ-024 ABORT: owner sees stall=1; -> IDLE when owner cyc low; other master not granted until then.
REQ-025 One-cycle dead time (IDLE) always separates two grants; no back-to-back owner switch.

Reset
REQ-026 i_rst_n low asynchronously forces: state IDLE, last_owner=1 (M0 wins first tie), watchdog 0.
REQ-027 During and immediately after reset: all o_s_* = 0, o_mN_stall=1, o_mN_ack=0, o_mN_err=0, o_mN_dat=0.
REQ-028 Reset mid-transaction aborts it with no ack/err; masters reissue after release.

Structure
REQ-029 State encodings and wr_size codes (1,2,4) in shared package leiwand_rv32_bus_pkg, reused by RAM and core.
REQ-030 Watchdog counter is sub-module leiwand_rv32_bus_watchdog (clear, enable, expire); width sized by HIGH_BIT_TO_FIT(TIMEOUT_CYCLES).

Verification
REQ-031 Single M0 read addr 0x10 with RAM behind arbiter -> grant next cycle, o_m0_ack once, o_m0_dat = RAM word 4; o_m1_stall=1 throughout.
REQ-032 M0 and M1 cyc rise same cycle after reset -> M0 granted; M0 drops cyc -> one IDLE cycle -> M1 granted; repeat tie -> M0 wins (round-robin).
REQ-033 M1 byte write 0xAB, addr 0x21, wr_size 1, during M0 pending -> o_s_wr_size=1, o_s_addr=0x21; later M0 read addr 0x20 returns byte1=0xAB.
REQ-034 Slave ack tied 0, TIMEOUT_CYCLES=4 -> o_m0_err pulse exactly on 4th unacked cycle, o_s_cyc=0, no ack; M1 blocked until M0 cyc low.
REQ-035 Assert i_rst_n=0 mid M1 write, asynchronously -> outputs per REQ-027 before next edge; after release first tie goes to M0.
